// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants, decode enums and immediate helper
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BR, CLS_LD, CLS_ST
    } cls_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        cls_e        cls;
        alu_op_e     alu_op;
        logic [31:0] imm;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } dec_t;

    function automatic logic [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I instruction decoder
module decode_comb
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    imm_fmt_e   fmt;
    cls_e       cls;
    alu_op_e    alu_op;
    logic       u1, u2, wr, ill;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];

    always_comb begin
        fmt    = IMM_NONE;
        cls    = CLS_ALU;
        alu_op = ALU_ADD;
        u1     = 1'b0;
        u2     = 1'b0;
        wr     = 1'b0;
        ill    = 1'b0;
        case (opcode)
            OPC_LUI:    begin cls = CLS_LUI;   fmt = IMM_U; wr = 1'b1; end
            OPC_AUIPC:  begin cls = CLS_AUIPC; fmt = IMM_U; wr = 1'b1; end
            OPC_JAL:    begin cls = CLS_JAL;   fmt = IMM_J; wr = 1'b1; end
            OPC_JALR: begin
                cls = CLS_JALR; fmt = IMM_I; u1 = 1'b1; wr = 1'b1;
                ill = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                cls = CLS_BR; fmt = IMM_B; u1 = 1'b1; u2 = 1'b1;
                ill = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                cls = CLS_LD; fmt = IMM_I; u1 = 1'b1; wr = 1'b1;
                ill = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                cls = CLS_ST; fmt = IMM_S; u1 = 1'b1; u2 = 1'b1;
                ill = f3[2] || (f3 == 3'b011);
            end
            OPC_OP_IMM: begin
                fmt = IMM_I; u1 = 1'b1; wr = 1'b1;
                alu_op = alu_from_f3(f3, (f3 == 3'b101) && (f7 == 7'h20));
                ill = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                      ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OPC_OP: begin
                u1 = 1'b1; u2 = 1'b1; wr = 1'b1;
                alu_op = alu_from_f3(f3, f7 == 7'h20);
                ill = !((f7 == 7'h00) ||
                        ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            default: ill = 1'b1;
        endcase
    end

    // An illegal instruction carries nothing but its flag downstream
    always_comb begin
        dec         = '0;
        dec.illegal = ill;
        if (!ill) begin
            dec.cls       = cls;
            dec.alu_op    = alu_op;
            dec.imm       = gen_imm(fmt, instr);
            dec.uses_rs1  = u1;
            dec.uses_rs2  = u2;
            dec.writes_rd = wr && (rd != 5'd0);
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode/issue stage with bypass, scoreboard and output register
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rs1_val,
    input  logic [XLEN-1:0] rf_rs2_val,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_val,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [2:0]      ex_cls,
    output logic [3:0]      ex_alu_op,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic            ex_rd_we,
    output logic            ex_illegal
);

    dec_t             dec;
    logic [4:0]       rd;
    logic             byp1, byp2, wb_hits_rd;
    logic [XLEN-1:0]  src1, src2;
    logic [NREGS-1:0] busy, busy_nxt;
    logic             hazard, accept, kill;

    decode_comb u_decode_comb (
        .instr (if_instr),
        .dec   (dec)
    );

    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];
    assign rd     = if_instr[11:7];

    assign byp1       = wb_valid && (wb_rd == rf_rs1) && (rf_rs1 != 5'd0);
    assign byp2       = wb_valid && (wb_rd == rf_rs2) && (rf_rs2 != 5'd0);
    assign wb_hits_rd = wb_valid && (wb_rd == rd);

    assign src1 = (rf_rs1 == 5'd0) ? '0 : (byp1 ? wb_val : rf_rs1_val);
    assign src2 = (rf_rs2 == 5'd0) ? '0 : (byp2 ? wb_val : rf_rs2_val);

    assign hazard = (dec.uses_rs1  && busy[rf_rs1] && !byp1) ||
                    (dec.uses_rs2  && busy[rf_rs2] && !byp2) ||
                    (dec.writes_rd && busy[rd]     && !wb_hits_rd);

    assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
    assign accept   = if_valid && if_ready;
    assign kill     = flush && ex_valid && !ex_ready;

    // Set is applied last so a same-cycle issue to a retiring register wins
    always_comb begin
        busy_nxt = busy;
        if (wb_valid)
            busy_nxt[wb_rd] = 1'b0;
        if (kill && ex_rd_we)
            busy_nxt[ex_rd] = 1'b0;
        if (accept && dec.writes_rd)
            busy_nxt[rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_cls     <= '0;
            ex_alu_op  <= '0;
            ex_funct3  <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_pc      <= if_pc;
            ex_cls     <= dec.cls;
            ex_alu_op  <= dec.alu_op;
            ex_funct3  <= if_instr[14:12];
            ex_a       <= dec.uses_rs1 ? src1 : '0;
            ex_b       <= dec.uses_rs2 ? src2 : '0;
            ex_imm     <= dec.imm;
            ex_rd      <= dec.writes_rd ? rd : 5'd0;
            ex_rd_we   <= dec.writes_rd;
            ex_illegal <= dec.illegal;
        end else if (ex_valid && (ex_ready || flush)) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
